complex_xif_ctrl: RTL

//  CV-X-IF front-end for the combinational complex unit (op 0 = complex add, op 1 = conjugate).

---
 rtl/complex_xif_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/complex_xif_ctrl.sv
// CV-X-IF front-end for the combinational complex unit: decodes custom-0 ADD/CONJ,
// drives the unit from issue operands and returns results through an in-order FIFO.
module complex_xif_ctrl #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]         issue_rs1_i,
    input  logic [31:0]         issue_rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    output logic                cu_op_o,
    output logic [31:0]         cu_a_o,
    output logic [31:0]         cu_b_o,
    input  logic [31:0]         cu_c_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic [31:0]         result_data_o,
    output logic                result_we_o
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        OP_ADD  = 1'b0,
        OP_CONJ = 1'b1
    } cu_op_e;

    logic            hit;
    cu_op_e          op;
    logic            push;
    logic            pop;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            unused_instr;

    logic [ID_WIDTH-1:0] id_mem   [FIFO_DEPTH];
    logic [4:0]          rd_mem   [FIFO_DEPTH];
    logic [31:0]         data_mem [FIFO_DEPTH];

    // Register-source fields are don't-care for decode.
    assign unused_instr = ^issue_instr_i[24:15];

    always_comb begin
        hit = 1'b0;
        op  = OP_ADD;
        if (issue_instr_i[6:0] == 7'b0001011 && issue_instr_i[14:12] == 3'b000) begin
            if (issue_instr_i[31:25] == 7'h00) begin
                hit = 1'b1;
            end else if (issue_instr_i[31:25] == 7'h01) begin
                hit = 1'b1;
                op  = OP_CONJ;
            end
        end
    end

    assign cu_op_o = op;
    assign cu_a_o  = issue_rs1_i;
    assign cu_b_o  = issue_rs2_i;

    assign issue_ready_o     = (count < CW'(FIFO_DEPTH));
    assign issue_accept_o    = issue_valid_i & issue_ready_o & hit;
    assign issue_writeback_o = issue_accept_o;

    assign push = issue_accept_o;
    assign pop  = result_valid_o & result_ready_i;

    assign result_valid_o = (count != '0);
    assign result_we_o    = result_valid_o;
    assign result_id_o    = id_mem[rd_ptr];
    assign result_rd_o    = rd_mem[rd_ptr];
    assign result_data_o  = data_mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                id_mem[i]   <= '0;
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                id_mem[wr_ptr]   <= issue_id_i;
                rd_mem[wr_ptr]   <= issue_instr_i[11:7];
                data_mem[wr_ptr] <= cu_c_i;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
